// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller:
//     - controller state encoding (run / drain / halted)
//     - forwarding-mux select encodings (FWD_RF, FWD_MEM, FWD_WB)
//     - performance counter width and a saturating increment helper
//     - register-index width and drain length
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam int unsigned REG_W        = 5;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned DRAIN_CYCLES = 3;

    // Drain counter value on the last drain cycle.
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Operand source selects for the EX-stage ALU input muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef logic [CNT_W-1:0] cnt_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t value);
        return (value == '1) ? value : value + cnt_t'(1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
//   Forwarding comparator for one EX-stage source operand.
//   Ports:
//     rs      in  source register read by the instruction in EX
//     mem_rd  in  EX_MEM destination register
//     mem_we  in  EX_MEM register write enable
//     wb_rd   in  MEM_WB destination register
//     wb_we   in  MEM_WB register write enable
//     sel     out operand source: FWD_MEM, FWD_WB or FWD_RF
//   The younger (EX_MEM) producer wins over MEM_WB; x0 is never forwarded.
// ---------------------------------------------------------------------------
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_we,
    output logic [1:0]       sel
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_we && (mem_rd != '0) && (mem_rd == rs);
        wb_hit  = wb_we  && (wb_rd  != '0) && (wb_rd  == rs);
        sel     = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and debug-halt controller for a 5-stage in-order pipeline.
//   Ports:
//     clk, rst                      clock; asynchronous active-low reset
//     id_rs1/id_rs2, id_use_rs1/2   ID-stage sources and their use flags
//     ex_rs1/ex_rs2/ex_rd           ID_EX sources and destination
//     ex_we_reg, ex_is_load         ID_EX write enable and load flag
//     mem_rd/mem_we_reg             EX_MEM destination and write enable
//     wb_rd/wb_we_reg               MEM_WB destination and write enable
//     ex_redirect                   taken branch/jump resolved in EX
//     dbg_halt_req/dbg_halt_ack     debug halt handshake
//     pc_we, if_id_we, if_id_nop,
//     id_ex_we, id_ex_nop,
//     ex_mem_nop                    pipeline-register controls
//     fwd_a_sel/fwd_b_sel           EX operand forwarding selects
//     stall_cnt/flush_cnt           saturating performance counters
//   A halt request is accepted only on a clean RUN cycle, then bubbles are
//   injected for DRAIN_CYCLES cycles so EX/MEM/WB empty before the ack.
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,

    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,

    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_we_reg,
    input  logic             ex_is_load,

    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_we_reg,

    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_we_reg,

    input  logic             ex_redirect,

    input  logic             dbg_halt_req,
    output logic             dbg_halt_ack,

    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_nop,
    output logic             id_ex_we,
    output logic             id_ex_nop,
    output logic             ex_mem_nop,

    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,

    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state;
    logic [1:0] drain_cnt;
    logic       load_use;
    logic       unused_ex_we_reg;

    // The load flag already implies a register write, so the EX write
    // enable carries no extra information for hazard detection.
    assign unused_ex_we_reg = ex_we_reg;

    // ------------------------------------------------------------------
    // Forwarding: one comparator per EX operand, active in every state.
    // ------------------------------------------------------------------
    fwd_unit u_fwd_a (
        .rs     (ex_rs1),
        .mem_rd (mem_rd),
        .mem_we (mem_we_reg),
        .wb_rd  (wb_rd),
        .wb_we  (wb_we_reg),
        .sel    (fwd_a_sel)
    );

    fwd_unit u_fwd_b (
        .rs     (ex_rs2),
        .mem_rd (mem_rd),
        .mem_we (mem_we_reg),
        .wb_rd  (wb_rd),
        .wb_we  (wb_we_reg),
        .sel    (fwd_b_sel)
    );

    // ------------------------------------------------------------------
    // Load-use detection: the load result is not available until MEM,
    // so a dependent instruction in ID must wait one cycle.
    // ------------------------------------------------------------------
    always_comb begin
        load_use = ex_is_load && (ex_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // ------------------------------------------------------------------
    // Controller state, drain counter, halt ack and perf counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_RUN;
            drain_cnt    <= '0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
            dbg_halt_ack <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    dbg_halt_ack <= 1'b0;
                    if (ex_redirect) begin
                        flush_cnt <= sat_inc(flush_cnt);
                    end else if (load_use) begin
                        stall_cnt <= sat_inc(stall_cnt);
                    end else if (dbg_halt_req) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    // A dropped request does not cut the drain short; the
                    // controller still passes through HALTED once.
                    if (drain_cnt == DRAIN_LAST) begin
                        state        <= ST_HALTED;
                        drain_cnt    <= '0;
                        dbg_halt_ack <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                ST_HALTED: begin
                    if (!dbg_halt_req) begin
                        state        <= ST_RUN;
                        dbg_halt_ack <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_RUN;
                    drain_cnt    <= '0;
                    dbg_halt_ack <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pipeline-register controls. These follow the current-cycle hazard
    // inputs, and reset overrides them directly so the pipeline is held
    // in a known bubble state for the whole time rst is low.
    // ------------------------------------------------------------------
    always_comb begin
        pc_we      = 1'b1;
        if_id_we   = 1'b1;
        if_id_nop  = 1'b0;
        id_ex_we   = 1'b1;
        id_ex_nop  = 1'b0;
        ex_mem_nop = 1'b0;

        if (!rst) begin
            pc_we      = 1'b0;
            if_id_nop  = 1'b1;
            id_ex_nop  = 1'b1;
            ex_mem_nop = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_redirect) begin
                        // Squash the two younger instructions; the PC
                        // loads the redirect target.
                        if_id_nop = 1'b1;
                        id_ex_nop = 1'b1;
                    end else if (load_use) begin
                        pc_we     = 1'b0;
                        if_id_we  = 1'b0;
                        id_ex_nop = 1'b1;
                    end
                end
                ST_DRAIN, ST_HALTED: begin
                    pc_we     = 1'b0;
                    if_id_we  = 1'b0;
                    id_ex_nop = 1'b1;
                end
                default: begin
                    pc_we     = 1'b0;
                    if_id_we  = 1'b0;
                    id_ex_nop = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl: directed scenarios followed by
//   randomized traffic, compared against a behavioural model of the
//   controller (halt progress tracked as a countdown of drain cycles).
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_we_reg, ex_is_load;
    logic [4:0]  mem_rd;
    logic        mem_we_reg;
    logic [4:0]  wb_rd;
    logic        wb_we_reg;
    logic        ex_redirect;
    logic        dbg_halt_req;
    logic        dbg_halt_ack;
    logic        pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop, ex_mem_nop;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt, flush_cnt;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_we_reg    (ex_we_reg),
        .ex_is_load   (ex_is_load),
        .mem_rd       (mem_rd),
        .mem_we_reg   (mem_we_reg),
        .wb_rd        (wb_rd),
        .wb_we_reg    (wb_we_reg),
        .ex_redirect  (ex_redirect),
        .dbg_halt_req (dbg_halt_req),
        .dbg_halt_ack (dbg_halt_ack),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .if_id_nop    (if_id_nop),
        .id_ex_we     (id_ex_we),
        .id_ex_nop    (id_ex_nop),
        .ex_mem_nop   (ex_mem_nop),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state.
    bit          m_halted     = 1'b0;
    int          m_drain_left = 0;
    int unsigned m_stall      = 0;
    int unsigned m_flush      = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned sat16(input int unsigned v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] mrd,
                                           input logic mwe, input logic [4:0] wrd,
                                           input logic wwe);
        if (mwe && mrd != 0 && mrd == rs) return 2'b01;
        if (wwe && wrd != 0 && wrd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit ref_hazard();
        bit dep;
        dep = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
        return ex_is_load && ex_rd != 0 && dep;
    endfunction

    // Expected {pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop, ex_mem_nop}.
    function automatic logic [5:0] ref_ctrl();
        if (!rst)                              return 6'b011111;
        if (m_halted || m_drain_left > 0)      return 6'b000110;
        if (ex_redirect)                       return 6'b111110;
        if (ref_hazard())                      return 6'b000110;
        return 6'b110100;
    endfunction

    task automatic model_reset();
        m_halted = 1'b0; m_drain_left = 0; m_stall = 0; m_flush = 0;
    endtask

    // Advance the model over one rising edge using the inputs seen at it.
    task automatic model_edge();
        if (!m_halted && m_drain_left == 0) begin
            if (ex_redirect)       m_flush = sat16(m_flush);
            else if (ref_hazard()) m_stall = sat16(m_stall);
            else if (dbg_halt_req) m_drain_left = 3;
        end else if (m_drain_left > 0) begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1'b1;
        end else if (!dbg_halt_req) begin
            m_halted = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_we_reg = 0; ex_is_load = 0;
        mem_rd = 0; mem_we_reg = 0; wb_rd = 0; wb_we_reg = 0;
        ex_redirect = 0; dbg_halt_req = 0;
    endtask

    task automatic random_inputs();
        id_rs1     = 5'($urandom_range(0, 3));
        id_rs2     = 5'($urandom_range(0, 3));
        id_use_rs1 = 1'($urandom);
        id_use_rs2 = 1'($urandom);
        ex_rs1     = 5'($urandom_range(0, 3));
        ex_rs2     = 5'($urandom_range(0, 3));
        ex_rd      = 5'($urandom_range(0, 3));
        ex_we_reg  = 1'($urandom);
        ex_is_load = 1'($urandom);
        mem_rd     = 5'($urandom_range(0, 3));
        mem_we_reg = 1'($urandom);
        wb_rd      = 5'($urandom_range(0, 3));
        wb_we_reg  = 1'($urandom);
        ex_redirect = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 15) == 0) dbg_halt_req = ~dbg_halt_req;
    endtask

    // Entered at posedge+1 with inputs applied; leaves at the next posedge+1.
    task automatic run_cycle();
        #1;
        check("ctrl", {pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop, ex_mem_nop}, ref_ctrl());
        check("fwd_a", fwd_a_sel, ref_fwd(ex_rs1, mem_rd, mem_we_reg, wb_rd, wb_we_reg));
        check("fwd_b", fwd_b_sel, ref_fwd(ex_rs2, mem_rd, mem_we_reg, wb_rd, wb_we_reg));
        @(posedge clk);
        model_edge();
        #1;
        check("halt_ack", dbg_halt_ack, m_halted);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
    endtask

    // Asserts reset at the current (off-edge) time, checks the reset
    // values, then releases off-edge and returns at posedge+1.
    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        idle_inputs();
        #1;
        check("rst_ctrl", {pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop, ex_mem_nop}, ref_ctrl());
        check("rst_ack", dbg_halt_ack, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_flush", flush_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_ack", dbg_halt_ack, 0);
        check("rst_hold_exmem", ex_mem_nop, 1);
        #2;
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        int first_ack;
        idle_inputs();
        #1;
        apply_reset();

        // Load-use: one bubble, stall counted.
        ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        #1;
        check("lu_pc_we", pc_we, 0);
        check("lu_id_ex_nop", id_ex_nop, 1);
        @(posedge clk); model_edge(); #1;
        check("lu_stall", stall_cnt, 1);
        idle_inputs();
        run_cycle();
        check("lu_resume_pc", pc_we, 1);

        // Redirect beats a coincident load-use.
        #2;
        apply_reset();
        ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; ex_redirect = 1;
        #1;
        check("rd_if_id_nop", if_id_nop, 1);
        check("rd_id_ex_nop", id_ex_nop, 1);
        check("rd_pc_we", pc_we, 1);
        @(posedge clk); model_edge(); #1;
        check("rd_flush", flush_cnt, 1);
        check("rd_stall", stall_cnt, 0);
        idle_inputs();

        // Forward priority on operand B.
        ex_rs2 = 7; mem_rd = 7; wb_rd = 7; mem_we_reg = 1; wb_we_reg = 1;
        #1 check("fwd_b_mem", fwd_b_sel, 2'b01);
        mem_rd = 0;
        #1 check("fwd_b_wb", fwd_b_sel, 2'b10);
        ex_rs2 = 0; wb_rd = 0;
        #1 check("fwd_b_x0", fwd_b_sel, 2'b00);
        @(posedge clk); model_edge(); #1;
        idle_inputs();

        // Halt latency and release.
        dbg_halt_req = 1;
        first_ack = 0;
        for (int i = 1; i <= 8; i++) begin
            run_cycle();
            if (dbg_halt_ack && first_ack == 0) first_ack = i;
        end
        check("halt_latency", first_ack, 4);
        dbg_halt_req = 0;
        run_cycle();
        check("halt_rel_ack", dbg_halt_ack, 0);
        check("halt_rel_pc", pc_we, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            run_cycle();
        end

        // Stall counter saturation.
        idle_inputs();
        ex_is_load = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        check("sat_stall", stall_cnt, 16'hFFFF);
        check("sat_model", stall_cnt, m_stall);
        run_cycle();
        check("sat_hold", stall_cnt, 16'hFFFF);

        // Asynchronous reset in the middle of a drain.
        idle_inputs();
        dbg_halt_req = 1;
        run_cycle();
        run_cycle();
        check("drain_entered", m_drain_left > 0, 1);
        check("drain_no_ack", dbg_halt_ack, 0);
        #2;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            check("post_rst_no_ack", dbg_halt_ack, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
